vram_arbiter: RTL and testbench

Owns the 10x10 cell video memory and shares its single access port between the VGA scan-out reader and the CPU. The VGA scan-out reader has priority, and a starvation guard bounds the CPU's wait. The block sits between the top level and the `vga` block, replacing the static `video_memory` vector with a real addressable store. Each cell is one RRRGGGBB pixel value driven to `vga_r`/`vga_g`/`vga_b`.

---
 rtl/vv_pkg.sv | 22 ++
 rtl/vram_cell_array.sv | 39 +++
 rtl/vram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vv_pkg.sv
// Shared constants and enums for the video memory arbiter.
// Used by vram_arbiter and vram_cell_array.
package vv_pkg;

  localparam int CELLS    = 100;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int STARVE_W = 4;

  // Which requester owns the single memory port in a given cycle.
  typedef enum logic [1:0] {
    NONE,
    VGA,
    CPU
  } grant_e;

  typedef enum logic {
    CLEAR,
    SERVE
  } state_e;

endpackage

// File: rtl/vram_cell_array.sv
// Single-port, synchronous-read CELLS x DATA_W store with write enable.
// Out-of-range addresses drop writes and read back as zero.
module vram_cell_array #(
  parameter int CELLS  = vv_pkg::CELLS,
  parameter int ADDR_W = vv_pkg::ADDR_W,
  parameter int DATA_W = vv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [CELLS];
  logic [DATA_W-1:0] rdata_q;
  logic              in_range;

  assign in_range = (int'(addr) < CELLS);

  // NOTE: the storage array has no reset so it maps onto RAM; consumers
  // qualify rdata with their own valid flag.
  always_ff @(posedge clk) begin
    if (en) begin
      if (in_range) begin
        if (we) begin
          mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Video memory owner: shares one RAM port between VGA scan-out (priority) and CPU,
// with a starvation guard. Define VRAM_CLEAR_EN to compile in the post-reset clear sweep.
module vram_arbiter #(
  parameter int CELLS        = vv_pkg::CELLS,
  parameter int ADDR_W       = vv_pkg::ADDR_W,
  parameter int DATA_W       = vv_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busy
);

  import vv_pkg::*;

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  grant_e              grant;
  logic                forced;
  logic                serve;
  logic                clearing;
  logic [ADDR_W-1:0]   clear_addr;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                vga_rvalid_q, vga_rvalid_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                vga_miss_q, vga_miss_d;

  logic                arr_en;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

`ifdef VRAM_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == CLEAR) begin
      if (sweep_q == LAST_CELL) begin
        state_d = SERVE;
        sweep_d = '0;
      end else begin
        sweep_d = sweep_q + 1'b1;
      end
    end
  end

  assign serve      = (state_q == SERVE);
  assign busy       = (state_q == CLEAR);
  assign clearing   = (state_q == CLEAR) && !rst;
  assign clear_addr = sweep_q;
`else
  assign serve      = 1'b1;
  assign busy       = 1'b0;
  assign clearing   = 1'b0;
  assign clear_addr = '0;
`endif

  // Nothing is granted in a reset cycle, so reset never touches memory itself.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant  = NONE;
    forced = 1'b0;
    if (serve && !rst) begin
      if (cpu_req && (starve_q == STARVE_MAX)) begin
        grant  = CPU;
        forced = 1'b1;
      end else if (vga_req) begin
        grant = VGA;
      end else if (cpu_req) begin
        grant = CPU;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!serve || !cpu_req || (grant == CPU)) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    vga_rvalid_d = (grant == VGA);
    cpu_rvalid_d = (grant == CPU) && !cpu_we;
    vga_miss_d   = forced && vga_req;
  end

  // The clear sweep and the arbiter winner share the one array port.
  always_comb begin
    arr_en    = clearing || (grant != NONE);
    arr_we    = clearing || ((grant == CPU) && cpu_we);
    arr_addr  = vga_addr;
    arr_wdata = cpu_wdata;
    if (clearing) begin
      arr_addr  = clear_addr;
      arr_wdata = '0;
    end else if (grant == CPU) begin
      arr_addr = cpu_addr;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      vga_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vga_miss_q   <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      vga_rvalid_q <= vga_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vga_miss_q   <= vga_miss_d;
    end
  end

  vram_cell_array #(
    .CELLS  (CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cells (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign cpu_ack    = (grant == CPU);
  assign vga_rvalid = vga_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign vga_miss   = vga_miss_q;
  // Read data is only meaningful alongside its valid pulse; zero otherwise.
  assign vga_rdata  = vga_rvalid_q ? arr_rdata : '0;
  assign cpu_rdata  = cpu_rvalid_q ? arr_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected read/miss events,
// a negedge monitor pops and compares them. Honors VRAM_CLEAR_EN if defined.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vga_req = 1'b0;
  logic [6:0] vga_addr = '0;
  logic       vga_rvalid;
  logic [7:0] vga_rdata;
  logic       vga_miss;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [6:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ack;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t exp_vga[$];
  exp_t exp_cpu[$];
  int   exp_miss[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  vram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .vga_miss   (vga_miss),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue in cycle and data.
  always @(negedge clk) begin
    exp_t e;
    if (vga_rvalid) begin
      if (exp_vga.size() == 0) check("vga_rvalid spurious", vga_rvalid, 0);
      else begin
        e = exp_vga.pop_front();
        check("vga_rvalid cycle", cyc, e.cyc);
        check("vga_rdata", vga_rdata, e.data);
      end
    end
    if (cpu_rvalid) begin
      if (exp_cpu.size() == 0) check("cpu_rvalid spurious", cpu_rvalid, 0);
      else begin
        e = exp_cpu.pop_front();
        check("cpu_rvalid cycle", cyc, e.cyc);
        check("cpu_rdata", cpu_rdata, e.data);
      end
    end
    if (vga_miss) begin
      if (exp_miss.size() == 0) check("vga_miss spurious", vga_miss, 0);
      else check("vga_miss cycle", cyc, exp_miss.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic we, input logic [6:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input int exp_wait);
    int waited = 0;
    bit got = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
      else begin
        waited++;
        tick();
      end
    end
    check($sformatf("cpu_ack wait addr %0d", a), waited, exp_wait);
    if (got && !we) exp_cpu.push_back('{cyc + 1, exp_rd});
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic vga_rd(input logic [6:0] a, input logic [7:0] exp_rd);
    vga_req = 1'b1; vga_addr = a;
    @(negedge clk);
    exp_vga.push_back('{cyc + 1, exp_rd});
    tick();
    vga_req = 1'b0;
  endtask

  // Entered at a negedge; counts busy cycles and leaves at the negedge busy fell.
  task automatic count_busy(input int exp_n);
    int n = 0;
    while (busy && n < 300) begin
      n++;
      tick();
      @(negedge clk);
    end
    check("busy cycles", n, exp_n);
  endtask

  logic [6:0] va [4] = '{7'd0, 7'd10, 7'd50, 7'd99};
  logic [7:0] vv [4] = '{8'h11, 8'h22, 8'hE3, 8'h99};

  initial begin
    // Reset state
    tick(); tick();
    @(negedge clk);
    check("reset vga_rvalid", vga_rvalid, 0);
    check("reset cpu_rvalid", cpu_rvalid, 0);
    check("reset vga_miss", vga_miss, 0);
    check("reset cpu_ack", cpu_ack, 0);
    check("reset vga_rdata", vga_rdata, 0);
    check("reset cpu_rdata", cpu_rdata, 0);
    check("reset starve", dut.starve_q, 0);
`ifdef VRAM_CLEAR_EN
    check("reset busy", busy, 1);
`else
    check("reset busy", busy, 0);
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
`ifdef VRAM_CLEAR_EN
    count_busy(100);
    tick();
    cpu_op(1'b0, 7'd99, 8'h00, 8'h00, 0);
`else
    check("busy tied low", busy, 0);
    tick();
`endif

    // Write then VGA read in the next cycle; read-after-write on the CPU side
    cpu_op(1'b1, 7'd50, 8'hE3, 8'h00, 0);
    vga_rd(7'd50, 8'hE3);
    cpu_op(1'b1, 7'd0,  8'h11, 8'h00, 0);
    cpu_op(1'b1, 7'd10, 8'h22, 8'h00, 0);
    cpu_op(1'b1, 7'd99, 8'h99, 8'h00, 0);
    cpu_op(1'b1, 7'd7,  8'h3C, 8'h00, 0);
    cpu_op(1'b0, 7'd7,  8'h00, 8'h3C, 0);
    tick();

    // Starvation guard: VGA requests every cycle, CPU read from relative cycle 2
    for (int i = 0; i < 20; i++) begin
      vga_req = 1'b1; vga_addr = va[i % 4];
      cpu_req = (i >= 2 && i <= 6); cpu_we = 1'b0; cpu_addr = 7'd50;
      @(negedge clk);
      check($sformatf("starve cpu_ack i=%0d", i), cpu_ack, (i == 6));
      if (i == 6) begin
        exp_cpu.push_back('{cyc + 1, 8'hE3});
        exp_miss.push_back(cyc + 1);
      end else begin
        exp_vga.push_back('{cyc + 1, vv[i % 4]});
      end
      tick();
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    tick();

    // Out-of-range write dropped, reads return zero, in-range cells intact
    cpu_op(1'b1, 7'd100, 8'h55, 8'h00, 0);
    cpu_op(1'b0, 7'd100, 8'h00, 8'h00, 0);
    cpu_op(1'b0, 7'd127, 8'h00, 8'h00, 0);
    vga_rd(7'd100, 8'h00);
    for (int i = 0; i < 4; i++) vga_rd(va[i], vv[i]);
    vga_rd(7'd7, 8'h3C);
    tick(); tick();

    // Idle: no requests, no activity
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle cpu_ack", cpu_ack, 0);
      check("idle vga_rvalid", vga_rvalid, 0);
      check("idle cpu_rvalid", cpu_rvalid, 0);
      check("idle vga_miss", vga_miss, 0);
      check("idle starve", dut.starve_q, 0);
      tick();
    end

    // Reset in a read grant cycle: no rvalid afterwards
    vga_req = 1'b1; vga_addr = 7'd50; rst = 1'b1;
    @(negedge clk);
    check("reset-cycle cpu_ack", cpu_ack, 0);
    tick();
    rst = 1'b0; vga_req = 1'b0;
    @(negedge clk);
    check("rvalid dropped by reset", vga_rvalid, 0);
`ifdef VRAM_CLEAR_EN
    count_busy(100);
    tick();
    // Reset at sweep cell 40 restarts the full clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    @(negedge clk);
    check("busy during mid-clear reset", busy, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    count_busy(100);
    tick();
    cpu_op(1'b0, 7'd50, 8'h00, 8'h00, 0);
`else
    tick();
    cpu_op(1'b0, 7'd50, 8'h00, 8'hE3, 0);
`endif

    tick(); tick(); tick();
    check("vga queue drained", exp_vga.size(), 0);
    check("cpu queue drained", exp_cpu.size(), 0);
    check("miss queue drained", exp_miss.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
